hdlverifier_jtag_bus_master: RTL and testbench
==============================================

# hdlverifier_jtag_bus_master

JTAG-to-bus command controller for the FPGA data-capture path. It sits directly behind the JTAG vendor IP wrapper, runs in the TCK domain, and turns DR scans (capture/shift/update) into single read or write transactions on a simple request/acknowledge register bus. It also returns status and read data on the next DR capture. It is the only master of that bus on the JTAG side.

## Interface
Parameters:
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 32, bus data width.
- TIMEOUT, 255, maximum cycles in REQ waiting for bus_ack (1..65535).

Derived: DR_LEN = 2 + ADDR_WIDTH + DATA_WIDTH (50 by default).

Ports:
- tck  in  1  sole clock; all flops rising-edge.
- jtag_reset_n  in  1  asynchronous, active-low reset.
- tdi  in  1  serial data in, sampled when shift_dr=1.
- tdo  out  1  serial data out, equal to sr[0].
- capture_dr  in  1  DR capture strobe, already gated by the user select.
- shift_dr  in  1  DR shift enable, already gated.
- update_dr  in  1  DR update strobe, already gated.
- bus_req  out  1  transaction request; held high until ack or timeout.
- bus_we  out  1  1 = write, 0 = read; stable while bus_req=1.
- bus_addr  out  ADDR_WIDTH  transaction address; stable while bus_req=1.
- bus_wdata  out  DATA_WIDTH  write data; stable while bus_req=1.
- bus_ack  in  1  one-cycle completion from the slave.
- bus_rdata  in  DATA_WIDTH  read data, valid when bus_ack=1 and bus_we=0.
- busy  out  1  high whenever state = REQ.
- err  out  1  sticky error flag (overrun or timeout).

## Operation
- DR layout, shifted LSB first:
  - bits [1:0]: cmd. 00 = NOP, 01 = WRITE, 10 = READ, 11 = CLEAR.
  - bits [ADDR_WIDTH+1:2]: addr.
  - upper DATA_WIDTH bits: data.
- Capture: sr loads {rdata_hold, last_addr, err, busy}. Bit 0 is busy, bit 1 is err.
- Shift: sr <= {tdi, sr[DR_LEN-1:1]}.
- Update: decode sr.
- Strobe priority when more than one is asserted in a cycle: capture_dr > shift_dr > update_dr. Only the winning strobe acts.
- FSM states: IDLE and REQ.
  - IDLE, update with WRITE or READ: latch bus_addr, bus_wdata and bus_we from sr; set last_addr; clear the timeout counter; go to REQ.
  - IDLE, update with NOP: no effect.
  - Any state, update with CLEAR: err <= 0. Does not start a transaction and does not change state.
  - REQ, bus_ack=1: if read, rdata_hold <= bus_rdata; go to IDLE.
  - REQ, counter reaches TIMEOUT-1 with no ack: go to IDLE, err <= 1, rdata_hold unchanged.
  - REQ, update with WRITE or READ: command dropped, err <= 1 (overrun). This includes the cycle in which bus_ack arrives; the ack itself still completes normally.
- Timeout counter width: clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset values: all of the following are 0.
  - Outputs: tdo, bus_req, bus_we, bus_addr, bus_wdata, busy, err.
  - Internal: sr, rdata_hold, last_addr, counter; state = IDLE.
- Reset asserted mid-transaction: bus_req drops immediately (asynchronous) and any pending ack is ignored.
- bus_req rises in the cycle after the update edge (1-cycle latency) and falls in the cycle after the ack edge.
- Maximum bus_req high time is TIMEOUT cycles.
- busy and err are registered and reflect state after each edge.
- A capture in the same cycle as bus_ack captures the pre-ack rdata_hold and busy=1.
- tdo changes only on capture or shift edges.

## Structure
- Shared package `hdlverifier_jtag_pkg`:
  - cmd encodings (CMD_NOP, CMD_WRITE, CMD_READ, CMD_CLEAR).
  - state enum (ST_IDLE, ST_REQ).
  - DR_LEN function.
- One sub-module, `hdlverifier_jtag_dr_shifter`: capture/shift register with tdo. The parent holds the FSM, bus registers and timeout logic.

## Test plan
- Reset, then a WRITE scan (addr 0x0010, data 0xA5A5A5A5) with bus_ack 3 cycles after bus_req:
  - bus_req is high for exactly 3 cycles with bus_we=1 and matching addr/data.
  - The next capture shifts out busy=0, err=0.
- READ of addr 0x0004, slave returns 0x12345678 on ack:
  - The following capture/shift yields data 0x12345678, addr 0x0004, status 00 on tdo.
- READ with bus_ack never asserted and TIMEOUT=8:
  - bus_req is high for 8 cycles, then err=1, and the capture status reads 10.
  - A CLEAR scan returns err to 0.
- Second WRITE update issued while busy (including on the ack cycle):
  - The first transaction completes unchanged, the second never reaches the bus, err=1.
- Reset asserted while bus_req=1:
  - bus_req and busy go low without waiting for a clock.
  - Subsequent ack pulses cause no state change.
  - All outputs read 0.

Source files
------------

// File: rtl/hdlverifier_jtag_pkg.sv
// Shared definitions for the JTAG-to-bus command controller: command
// encodings carried in the low DR bits, FSM states, and DR length helper.
package hdlverifier_jtag_pkg;

  // Command field, DR bits [1:0]
  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  // Bus-side transaction state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // DR holds cmd (2 bits), then address, then data
  function automatic int dr_len(input int addr_width, input int data_width);
    return 2 + addr_width + data_width;
  endfunction

endpackage

// File: rtl/hdlverifier_jtag_dr_shifter.sv
// JTAG data register: parallel capture of status/read-back, LSB-first
// serial shift from tdi, with tdo always presenting bit 0.
module hdlverifier_jtag_dr_shifter #(
  parameter int DR_LEN = 50
) (
  input  logic              tck,
  input  logic              jtag_reset_n,
  input  logic              tdi,
  input  logic              capture_dr,
  input  logic              shift_dr,
  input  logic [DR_LEN-1:0] capture_data,
  output logic [DR_LEN-1:0] sr,
  output logic              tdo
);

  logic [DR_LEN-1:0] sr_q;
  logic [DR_LEN-1:0] sr_d;

  // Capture beats shift; update leaves the register untouched so the
  // parent can decode the scanned-in command from it.
  always_comb begin
    sr_d = sr_q;
    if (capture_dr) begin
      sr_d = capture_data;
    end else if (shift_dr) begin
      sr_d = {tdi, sr_q[DR_LEN-1:1]};
    end
  end

  // Shift register storage
  always_ff @(posedge tck or negedge jtag_reset_n) begin
    if (!jtag_reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr  = sr_q;
  // Driven straight from the flop, so tdo only moves on capture/shift edges
  assign tdo = sr_q[0];

endmodule

// File: rtl/hdlverifier_jtag_bus_master.sv
// JTAG-to-bus command controller. DR scans are decoded on update into a
// single read or write on a req/ack register bus; status and the last read
// data are returned on the next DR capture. Runs entirely in the TCK domain.
module hdlverifier_jtag_bus_master
  import hdlverifier_jtag_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  tck,
  input  logic                  jtag_reset_n,
  input  logic                  tdi,
  output logic                  tdo,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  busy,
  output logic                  err
);

  localparam int DR_LEN = dr_len(ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  // Last counter value before the request is abandoned; bus_req is then
  // high for exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_e                state_q, state_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [DATA_WIDTH-1:0] rdata_hold_q, rdata_hold_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // ---------------------------------------------------------------------
  // DR shifter
  // ---------------------------------------------------------------------
  logic [DR_LEN-1:0] sr;
  logic [DR_LEN-1:0] capture_data;

  // Read-back word, same field layout as a command: status in the cmd slot
  assign capture_data = {rdata_hold_q, last_addr_q, err_q, busy};

  hdlverifier_jtag_dr_shifter #(
    .DR_LEN(DR_LEN)
  ) u_dr_shifter (
    .tck          (tck),
    .jtag_reset_n (jtag_reset_n),
    .tdi          (tdi),
    .capture_dr   (capture_dr),
    .shift_dr     (shift_dr),
    .capture_data (capture_data),
    .sr           (sr),
    .tdo          (tdo)
  );

  // ---------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------
  cmd_e cmd;
  logic update_win;
  logic is_xfer;

  assign cmd        = cmd_e'(sr[1:0]);
  // Update only acts when neither capture nor shift is asserted with it
  assign update_win = update_dr & ~capture_dr & ~shift_dr;
  assign is_xfer    = (cmd == CMD_WRITE) || (cmd == CMD_READ);

  // ---------------------------------------------------------------------
  // FSM next state, bus latches, timeout and sticky error
  // ---------------------------------------------------------------------
  logic timeout_hit;
  logic overrun_hit;

  // Next-state and datapath decisions for one TCK cycle
  always_comb begin
    state_d      = state_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    last_addr_d  = last_addr_q;
    rdata_hold_d = rdata_hold_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    timeout_hit  = 1'b0;
    overrun_hit  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (update_win && is_xfer) begin
          bus_we_d    = (cmd == CMD_WRITE);
          bus_addr_d  = sr[ADDR_WIDTH+1:2];
          bus_wdata_d = sr[DR_LEN-1 -: DATA_WIDTH];
          last_addr_d = sr[ADDR_WIDTH+1:2];
          cnt_d       = '0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack wins over a timeout landing in the same cycle
        if (bus_ack) begin
          if (!bus_we_q) begin
            rdata_hold_d = bus_rdata;
          end
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A new transfer while one is outstanding is dropped, even on the
        // ack cycle; the outstanding one still completes normally.
        if (update_win && is_xfer) begin
          overrun_hit = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (update_win && (cmd == CMD_CLEAR)) begin
      err_d = 1'b0;
    end
    // A fresh error outranks a CLEAR arriving in the same cycle so no
    // failure is ever silently lost.
    if (timeout_hit || overrun_hit) begin
      err_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge tck or negedge jtag_reset_n) begin
    if (!jtag_reset_n) begin
      state_q      <= ST_IDLE;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      last_addr_q  <= '0;
      rdata_hold_q <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      last_addr_q  <= last_addr_d;
      rdata_hold_q <= rdata_hold_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Outputs come straight from flops; bus_req/busy drop as soon as the
  // asynchronous reset clears state_q.
  assign bus_req   = (state_q == ST_REQ);
  assign busy      = (state_q == ST_REQ);
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_hdlverifier_jtag_bus_master.sv
// Self-checking bench for hdlverifier_jtag_bus_master: drives JTAG DR scans,
// answers the bus with a latency-programmable memory slave, and compares
// bus traffic and captured status against a transaction-level model.
module tb_hdlverifier_jtag_bus_master;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam int DRL = 2 + AW + DW;

  localparam logic [1:0] C_NOP = 2'd0;
  localparam logic [1:0] C_WR  = 2'd1;
  localparam logic [1:0] C_RD  = 2'd2;
  localparam logic [1:0] C_CLR = 2'd3;

  logic          tck = 1'b0;
  logic          jtag_reset_n = 1'b0;
  logic          tdi = 1'b0;
  logic          tdo;
  logic          capture_dr = 1'b0;
  logic          shift_dr = 1'b0;
  logic          update_dr = 1'b0;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic          busy;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 tck = ~tck;

  hdlverifier_jtag_bus_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .tck          (tck),
    .jtag_reset_n (jtag_reset_n),
    .tdi          (tdi),
    .tdo          (tdo),
    .capture_dr   (capture_dr),
    .shift_dr     (shift_dr),
    .update_dr    (update_dr),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .busy         (busy),
    .err          (err)
  );

  // Contents of a never-written slave location
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  // ---------------------------------------------------------------
  // Bus slave: acks after slave_lat cycles of bus_req (0 = never)
  // ---------------------------------------------------------------
  int            slave_lat = 1;
  logic          force_ack = 1'b0;
  int            slave_age = 0;
  logic [DW-1:0] slave_mem [logic [AW-1:0]];

  initial begin
    slave_mem[16'h0004] = 32'h12345678;
    forever begin
      @(posedge tck);
      #2;
      bus_ack   = 1'b0;
      bus_rdata = $urandom();
      if (jtag_reset_n === 1'b1 && bus_req === 1'b1) begin
        slave_age++;
        if (slave_lat != 0 && slave_age == slave_lat) begin
          bus_ack = 1'b1;
          if (bus_we)
            slave_mem[bus_addr] = bus_wdata;
          else
            bus_rdata = slave_mem.exists(bus_addr) ? slave_mem[bus_addr] : dflt(bus_addr);
        end
      end else begin
        slave_age = 0;
      end
      if (force_ack) bus_ack = 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Bus monitor: logs each bus_req pulse (fields, length, ack, stability)
  // ---------------------------------------------------------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cycles;
    logic          acked;
    logic          stable;
  } txn_t;

  txn_t mon_log[$];
  txn_t cur;
  int   mon_cycles = 0;

  always @(negedge tck) begin
    if (jtag_reset_n !== 1'b1) begin
      mon_cycles = 0;
    end else if (bus_req === 1'b1) begin
      if (mon_cycles == 0) begin
        cur.we     = bus_we;
        cur.addr   = bus_addr;
        cur.wdata  = bus_wdata;
        cur.stable = 1'b1;
      end else if ({bus_we, bus_addr, bus_wdata} !== {cur.we, cur.addr, cur.wdata}) begin
        cur.stable = 1'b0;
      end
      mon_cycles++;
      if (bus_ack === 1'b1) begin
        cur.cycles = mon_cycles;
        cur.acked  = 1'b1;
        mon_log.push_back(cur);
        mon_cycles = 0;
      end
    end else if (mon_cycles != 0) begin
      cur.cycles = mon_cycles;
      cur.acked  = 1'b0;
      mon_log.push_back(cur);
      mon_cycles = 0;
    end
  end

  // ---------------------------------------------------------------
  // Reference model state (what the next capture should return)
  // ---------------------------------------------------------------
  logic [DW-1:0] m_rdata = '0;
  logic [AW-1:0] m_last  = '0;
  logic          m_err   = 1'b0;
  logic [DW-1:0] m_mem [logic [AW-1:0]];
  int            rd_idx  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic do_capture();
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
  endtask

  task automatic do_shift(input logic [DRL-1:0] din, output logic [DRL-1:0] dout);
    shift_dr = 1'b1;
    for (int i = 0; i < DRL; i++) begin
      dout[i] = tdo;
      tdi = din[i];
      tick();
    end
    shift_dr = 1'b0;
  endtask

  task automatic do_update();
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
  endtask

  task automatic scan(input logic [DRL-1:0] din, output logic [DRL-1:0] dout);
    do_capture();
    do_shift(din, dout);
    do_update();
  endtask

  function automatic logic [DRL-1:0] mk(input logic [1:0] c, input logic [AW-1:0] a,
                                        input logic [DW-1:0] d);
    return {d, a, c};
  endfunction

  // Bounded wait for the bus to go quiet, plus one cycle for the monitor
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus_req !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, bus_req, 1'b0);
    tick();
  endtask

  task automatic expect_none(input string tag);
    check({tag, "_nobus"}, mon_log.size() - rd_idx, 0);
    rd_idx = mon_log.size();
  endtask

  // Check one logged bus transaction and advance the model
  task automatic expect_txn(input string tag, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int lat);
    txn_t t;
    check({tag, "_ntxn"}, mon_log.size() - rd_idx, 1);
    if (mon_log.size() > rd_idx) begin
      t = mon_log[rd_idx];
      check({tag, "_fields"}, {t.we, t.addr, t.wdata}, {we, a, d});
      check({tag, "_len"}, t.cycles, (lat == 0) ? TO : lat);
      check({tag, "_acked"}, t.acked, (lat != 0));
      check({tag, "_stable"}, t.stable, 1'b1);
    end
    rd_idx = mon_log.size();
    m_last = a;
    if (lat == 0)
      m_err = 1'b1;
    else if (we)
      m_mem[a] = d;
    else
      m_rdata = m_mem.exists(a) ? m_mem[a] : dflt(a);
  endtask

  // One complete command scan with capture check, bus check and err check
  task automatic run_cmd(input string tag, input logic [1:0] c, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int lat);
    logic [DRL-1:0] dout;
    slave_lat = lat;
    scan(mk(c, a, d), dout);
    check({tag, "_cap"}, dout, {m_rdata, m_last, m_err, 1'b0});
    wait_idle(tag);
    if (c == C_WR || c == C_RD) begin
      expect_txn(tag, (c == C_WR), a, d, lat);
    end else begin
      expect_none(tag);
      if (c == C_CLR) m_err = 1'b0;
    end
    check({tag, "_err"}, err, m_err);
    $display("[TB] txn %s cmd=%0d addr=%h data=%h lat=%0d err=%b", tag, c, a, d, lat, err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DRL-1:0] dout;
    logic [AW-1:0]  pool [6];
    logic [1:0]     rc;
    logic [AW-1:0]  ra;
    logic [DW-1:0]  rdat;
    int             rl;

    pool[0] = 16'h0004; pool[1] = 16'h0010; pool[2] = 16'h0020;
    pool[3] = 16'h0100; pool[4] = 16'hBEEC; pool[5] = 16'h0008;
    m_mem[16'h0004] = 32'h12345678;

    // Reset
    tick(); tick(); tick();
    jtag_reset_n = 1'b1;
    tick();
    check("rst_bus", {bus_req, bus_we, bus_addr, bus_wdata}, '0);
    check("rst_stat", {tdo, busy, err}, 3'b000);
    $display("[TB] txn reset released");

    // Basic write and read
    run_cmd("wr10", C_WR, 16'h0010, 32'hA5A5A5A5, 3);
    run_cmd("rd04", C_RD, 16'h0004, 32'h0, 2);
    run_cmd("nop_after_rd", C_NOP, 16'h0, 32'h0, 1);

    // Timeout, sticky err visible on capture, then CLEAR
    run_cmd("rd_timeout", C_RD, 16'h0008, 32'h0, 0);
    run_cmd("nop_err", C_NOP, 16'h0, 32'h0, 1);
    run_cmd("clear1", C_CLR, 16'h0, 32'h0, 1);
    run_cmd("nop_clean", C_NOP, 16'h0, 32'h0, 1);

    // Overrun mid-request: sr still holds the WRITE, so re-pulse update
    slave_lat = 5;
    scan(mk(C_WR, 16'h0020, 32'hDEADBEEF), dout);
    check("ovr_cap", dout, {m_rdata, m_last, m_err, 1'b0});
    tick();
    do_update();
    check("ovr_busy", {bus_req, err}, 2'b11);
    wait_idle("ovr");
    expect_txn("ovr", 1'b1, 16'h0020, 32'hDEADBEEF, 5);
    m_err = 1'b1;
    tick(); tick();
    expect_none("ovr_second");
    check("ovr_err", err, m_err);
    $display("[TB] txn overrun mid-request err=%b", err);
    run_cmd("clear2", C_CLR, 16'h0, 32'h0, 1);

    // Overrun landing on the ack edge of a READ
    slave_lat = 3;
    scan(mk(C_RD, 16'h0004, 32'h0), dout);
    check("ovack_cap", dout, {m_rdata, m_last, m_err, 1'b0});
    tick(); tick();
    do_update();
    check("ovack_done", {bus_req, err}, 2'b01);
    wait_idle("ovack");
    expect_txn("ovack", 1'b0, 16'h0004, 32'h0, 3);
    m_err = 1'b1;
    tick(); tick();
    expect_none("ovack_second");
    $display("[TB] txn overrun on ack err=%b", err);
    run_cmd("clear3", C_CLR, 16'h0, 32'h0, 1);

    // Capture on the ack edge returns pre-ack rdata and busy=1
    slave_lat = 3;
    scan(mk(C_RD, 16'h0010, 32'h0), dout);
    check("capack_cap", dout, {m_rdata, m_last, m_err, 1'b0});
    tick(); tick();
    do_capture();
    do_shift(mk(C_NOP, 16'h0, 32'h0), dout);
    check("capack_word", dout, {m_rdata, 16'h0010, m_err, 1'b1});
    do_update();
    wait_idle("capack");
    expect_txn("capack", 1'b0, 16'h0010, 32'h0, 3);
    $display("[TB] txn capture on ack rdata=%h", m_rdata);

    // Randomized command stream
    for (int k = 0; k < 30; k++) begin
      rc   = 2'($urandom_range(0, 3));
      ra   = pool[$urandom_range(0, 5)];
      rdat = $urandom();
      rl   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
      run_cmd($sformatf("rnd%0d", k), rc, ra, rdat, rl);
    end

    // Reset while bus_req is high (err also set beforehand)
    run_cmd("pre_rst_to", C_RD, 16'h0100, 32'h0, 0);
    slave_lat = 0;
    scan(mk(C_WR, 16'h0044, 32'h01020304), dout);
    tick(); tick();
    check("mid_req", {bus_req, busy, err}, 3'b111);
    jtag_reset_n = 1'b0;
    #1;
    check("async_drop", {bus_req, busy}, 2'b00);
    force_ack = 1'b1;
    tick(); tick();
    jtag_reset_n = 1'b1;
    tick(); tick(); tick();
    force_ack = 1'b0;
    tick();
    check("post_rst_bus", {bus_req, bus_we, bus_addr, bus_wdata}, '0);
    check("post_rst_stat", {tdo, busy, err}, 3'b000);
    rd_idx  = mon_log.size();
    m_rdata = '0;
    m_last  = '0;
    m_err   = 1'b0;
    $display("[TB] txn reset during request");
    run_cmd("post_rst_nop", C_NOP, 16'h0, 32'h0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
